// File: rtl/uart_tx_scheduler.sv
// COREUART transmit scheduler: round-robin ack/report arbitration, 6-byte frame serialiser, TXRDY watchdog.
// Build option UART_TX_CHECKSUM_EN appends a 7th byte = XOR of addr and the four data bytes.
module uart_tx_scheduler #(
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned GUARD_CYC   = 4,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic        sys_clk_i,
    input  logic        reset_i,
    input  logic        ack_req_i,
    input  logic [7:0]  ack_addr_i,
    input  logic [31:0] ack_data_i,
    output logic        ack_gnt_o,
    input  logic        rpt_req_i,
    input  logic [7:0]  rpt_addr_i,
    input  logic [31:0] rpt_data_i,
    output logic        rpt_gnt_o,
    input  logic        tx_rdy_i,
    output logic        wen_o,
    output logic [7:0]  tx_data_o,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic        err_o,
    output logic [2:0]  state_o
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_RDY = 3'd1,
        WRITE    = 3'd2,
        GUARD    = 3'd3,
        DONE     = 3'd4
    } state_t;

`ifdef UART_TX_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd6;
`else
    localparam logic [2:0] LAST_IDX = 3'd5;
`endif
    localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYC - 1);
    localparam logic [3:0]  GUARD_LAST = 4'(GUARD_CYC - 1);

    state_t      state_q;
    logic [2:0]  byte_idx_q;
    logic [39:0] shadow_q;
    logic        last_ack_q;
    logic [15:0] tmo_q;
    logic [3:0]  grd_q;
    logic        wen_q;
    logic [7:0]  tx_data_q;
    logic        done_q;
    logic        err_q;

    logic        ack_sel;
    logic        rpt_sel;
    logic [7:0]  cur_byte;

    // Requesters hold req high until they see their one-cycle gnt; inputs are captured on that cycle's edge.
    // The gnt is decoded combinationally in IDLE so a grant is followed directly by WAIT_RDY.
    always_comb begin
        ack_sel = 1'b0;
        rpt_sel = 1'b0;
        if (reset_i && state_q == IDLE && !err_q) begin
            if (ack_req_i && rpt_req_i) begin
                ack_sel = !last_ack_q;
                rpt_sel = last_ack_q;
            end else begin
                ack_sel = ack_req_i;
                rpt_sel = rpt_req_i;
            end
        end
    end

    always_comb begin
        cur_byte = 8'h00;
        case (byte_idx_q)
            3'd0: cur_byte = SYNC_BYTE;
            3'd1: cur_byte = shadow_q[39:32];
            3'd2: cur_byte = shadow_q[31:24];
            3'd3: cur_byte = shadow_q[23:16];
            3'd4: cur_byte = shadow_q[15:8];
            3'd5: cur_byte = shadow_q[7:0];
`ifdef UART_TX_CHECKSUM_EN
            3'd6: cur_byte = shadow_q[39:32] ^ shadow_q[31:24] ^ shadow_q[23:16]
                           ^ shadow_q[15:8] ^ shadow_q[7:0];
`endif
            default: cur_byte = 8'h00;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= IDLE;
            byte_idx_q <= 3'd0;
            shadow_q   <= 40'h0;
            last_ack_q <= 1'b0;
            tmo_q      <= 16'h0;
            grd_q      <= 4'h0;
            wen_q      <= 1'b1;
            tx_data_q  <= 8'h00;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wen_q  <= 1'b1;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ack_sel || rpt_sel) begin
                        shadow_q   <= ack_sel ? {ack_addr_i, ack_data_i} : {rpt_addr_i, rpt_data_i};
                        last_ack_q <= ack_sel;
                        byte_idx_q <= 3'd0;
                        tmo_q      <= 16'h0;
                        state_q    <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (tx_rdy_i) begin
                        wen_q     <= 1'b0;
                        tx_data_q <= cur_byte;
                        state_q   <= WRITE;
                    end else if (tmo_q == TMO_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end
                WRITE: begin
                    grd_q   <= 4'h0;
                    state_q <= GUARD;
                end
                GUARD: begin
                    if (grd_q == GUARD_LAST) begin
                        if (byte_idx_q == LAST_IDX) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            byte_idx_q <= byte_idx_q + 3'd1;
                            tmo_q      <= 16'h0;
                            state_q    <= WAIT_RDY;
                        end
                    end else begin
                        grd_q <= grd_q + 4'd1;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack_gnt_o    = ack_sel;
    assign rpt_gnt_o    = rpt_sel;
    assign wen_o        = wen_q;
    assign tx_data_o    = tx_data_q;
    assign busy_o       = (state_q != IDLE);
    assign frame_done_o = done_q;
    assign err_o        = err_q;
    assign state_o      = state_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: main instance (default watchdog) plus a second instance with TIMEOUT_CYC=50.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;
    localparam int GUARD = 4;
`ifdef UART_TX_CHECKSUM_EN
    localparam int NBYTES = 7;
`else
    localparam int NBYTES = 6;
`endif
    localparam int PERIOD = 6 * NBYTES + 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ack_req, rpt_req, tx_rdy;
    logic [7:0]  ack_addr, rpt_addr;
    logic [31:0] ack_data, rpt_data;
    logic        ack_gnt, rpt_gnt, wen, busy, done, err;
    logic [7:0]  tx_data;
    logic [2:0]  state_dbg;
    logic        wd_ack_req, wd_rpt_req, wd_rdy;
    logic        wd_ack_gnt, wd_rpt_gnt, wd_wen, wd_busy, wd_done, wd_err;
    logic [7:0]  wd_tx_data;
    logic [2:0]  wd_state;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_tx_scheduler dut (
        .sys_clk_i(clk), .reset_i(reset_n),
        .ack_req_i(ack_req), .ack_addr_i(ack_addr), .ack_data_i(ack_data), .ack_gnt_o(ack_gnt),
        .rpt_req_i(rpt_req), .rpt_addr_i(rpt_addr), .rpt_data_i(rpt_data), .rpt_gnt_o(rpt_gnt),
        .tx_rdy_i(tx_rdy), .wen_o(wen), .tx_data_o(tx_data), .busy_o(busy),
        .frame_done_o(done), .err_o(err), .state_o(state_dbg)
    );

    uart_tx_scheduler #(.TIMEOUT_CYC(50)) dut_wd (
        .sys_clk_i(clk), .reset_i(reset_n),
        .ack_req_i(wd_ack_req), .ack_addr_i(ack_addr), .ack_data_i(ack_data), .ack_gnt_o(wd_ack_gnt),
        .rpt_req_i(wd_rpt_req), .rpt_addr_i(rpt_addr), .rpt_data_i(rpt_data), .rpt_gnt_o(wd_rpt_gnt),
        .tx_rdy_i(wd_rdy), .wen_o(wd_wen), .tx_data_o(wd_tx_data), .busy_o(wd_busy),
        .frame_done_o(wd_done), .err_o(wd_err), .state_o(wd_state)
    );

    // Event recorder: samples 1ns after each falling edge, logs strobes, grants and pulses with cycle stamps.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] wen_data_q[$];
    int wen_cyc_q[$], gnt_who_q[$], gnt_cyc_q[$], wd_wen_cyc_q[$], wd_gnt_cyc_q[$];
    int done_cnt, done_cyc, err_cnt, both_cnt, wd_err_cnt, wd_err_cyc, wd_done_cnt;
    logic wd_busy_at_err;

    always @(negedge clk) begin
        #1;
        if (wen === 1'b0) begin wen_data_q.push_back(tx_data); wen_cyc_q.push_back(cyc); end
        if (ack_gnt === 1'b1) begin gnt_who_q.push_back(0); gnt_cyc_q.push_back(cyc); end
        if (rpt_gnt === 1'b1) begin gnt_who_q.push_back(1); gnt_cyc_q.push_back(cyc); end
        if (ack_gnt === 1'b1 && rpt_gnt === 1'b1) both_cnt++;
        if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (err === 1'b1) err_cnt++;
        if (wd_wen === 1'b0) wd_wen_cyc_q.push_back(cyc);
        if (wd_ack_gnt === 1'b1 || wd_rpt_gnt === 1'b1) wd_gnt_cyc_q.push_back(cyc);
        if (wd_err === 1'b1) begin wd_err_cnt++; wd_err_cyc = cyc; wd_busy_at_err = wd_busy; end
        if (wd_done === 1'b1) wd_done_cnt++;
    end

    task automatic clear_mon();
        wen_data_q.delete(); wen_cyc_q.delete(); gnt_who_q.delete(); gnt_cyc_q.delete();
        wd_wen_cyc_q.delete(); wd_gnt_cyc_q.delete();
        done_cnt = 0; done_cyc = 0; err_cnt = 0; both_cnt = 0;
        wd_err_cnt = 0; wd_err_cyc = 0; wd_done_cnt = 0; wd_busy_at_err = 1'bx;
    endtask

    task automatic make_exp(input logic [7:0] a, input logic [31:0] d);
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(a);
        exp_q.push_back(d[31:24]);
        exp_q.push_back(d[23:16]);
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[7:0]);
`ifdef UART_TX_CHECKSUM_EN
        exp_q.push_back(a ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0]);
`endif
    endtask

    // Called on a falling edge; returns on the falling edge after the grant with ack_req dropped.
    task automatic request_ack(input logic [7:0] a, input logic [31:0] d, input bit change_after,
                               output bit granted);
        ack_addr = a;
        ack_data = d;
        ack_req  = 1'b1;
        granted  = 1'b0;
        for (int i = 0; i < 60 && !granted; i++) begin
            #1;
            if (ack_gnt === 1'b1) granted = 1'b1;
            @(negedge clk);
        end
        ack_req = 1'b0;
        if (change_after) ack_data = 32'hFFFF_FFFF;
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < max_cyc) begin @(negedge clk); n++; end
        ok = (busy === 1'b0);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ack_req = 1'b1; rpt_req = 1'b1; tx_rdy = 1'b1;
        ack_addr = 8'h00; ack_data = 32'h0; rpt_addr = 8'h00; rpt_data = 32'h0;
        wd_ack_req = 1'b0; wd_rpt_req = 1'b0; wd_rdy = 1'b1;
        clear_mon();
        repeat (3) @(negedge clk);
        #1;
        checks++; if (wen !== 1'b1) begin errors++; $display("FAIL reset_wen: got %b want 1", wen); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        checks++; if (ack_gnt !== 1'b0 || rpt_gnt !== 1'b0) begin
            errors++; $display("FAIL reset_gnt: got ack=%b rpt=%b want 0 0", ack_gnt, rpt_gnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL reset_pulses: got done=%b err=%b want 0 0", done, err); end
        checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
        ack_req = 1'b0; rpt_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_ack();
        bit granted, ok;
        int last;
        clear_mon();
        tx_rdy = 1'b1;
        request_ack(8'h03, 32'h1234_5678, 1'b0, granted);
        checks++; if (!granted) begin errors++; $display("FAIL single_grant: got none want ack_gnt pulse"); end
        wait_idle(400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_idle: busy_o still 1 want 0"); end
        make_exp(8'h03, 32'h1234_5678);
        checks++; if (wen_data_q.size() != NBYTES) begin
            errors++; $display("FAIL single_strobes: got %0d want %0d", wen_data_q.size(), NBYTES); end
        for (int i = 0; i < wen_data_q.size() && i < NBYTES; i++) begin
            checks++; if (wen_data_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL single_byte%0d: got %h want %h", i, wen_data_q[i], exp_q[i]); end
        end
        for (int i = 1; i < wen_cyc_q.size(); i++) begin
            checks++; if (wen_cyc_q[i] - wen_cyc_q[i-1] != GUARD + 2) begin
                errors++; $display("FAIL single_spacing%0d: got %0d want %0d", i, wen_cyc_q[i] - wen_cyc_q[i-1], GUARD + 2); end
        end
        checks++; if (gnt_who_q.size() != 1 || gnt_who_q[0] != 0) begin
            errors++; $display("FAIL single_gnt_count: got %0d grants want 1 ack", gnt_who_q.size()); end
        if (gnt_cyc_q.size() > 0 && wen_cyc_q.size() > 0) begin
            checks++; if (wen_cyc_q[0] - gnt_cyc_q[0] != 2) begin
                errors++; $display("FAIL single_latency: got %0d want 2", wen_cyc_q[0] - gnt_cyc_q[0]); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL single_done: got %0d want 1", done_cnt); end
        if (wen_cyc_q.size() > 0) begin
            last = wen_cyc_q[wen_cyc_q.size()-1];
            checks++; if (done_cyc != last + GUARD + 1) begin
                errors++; $display("FAIL single_done_time: got %0d want %0d", done_cyc, last + GUARD + 1); end
        end
        checks++; if (err_cnt != 0) begin errors++; $display("FAIL single_err: got %0d want 0", err_cnt); end
    endtask

    task automatic test_contention();
        int n;
        bit ok;
        reset_n = 1'b0;
        ack_req = 1'b1; rpt_req = 1'b1; tx_rdy = 1'b1;
        ack_addr = 8'h11; ack_data = 32'hAABB_CCDD; rpt_addr = 8'h22; rpt_data = 32'h0102_0304;
        repeat (2) @(negedge clk);
        clear_mon();
        reset_n = 1'b1;
        n = 0;
        while (gnt_cyc_q.size() < 4 && n < 4 * PERIOD + 20) begin @(negedge clk); n++; end
        ack_req = 1'b0; rpt_req = 1'b0;
        wait_idle(PERIOD + 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL cont_idle: busy_o still 1 want 0"); end
        checks++; if (gnt_who_q.size() != 4) begin
            errors++; $display("FAIL cont_gnt_count: got %0d want 4", gnt_who_q.size()); end
        for (int i = 0; i < gnt_who_q.size() && i < 4; i++) begin
            checks++; if (gnt_who_q[i] != (i % 2)) begin
                errors++; $display("FAIL cont_order%0d: got %0d want %0d (0=ack 1=rpt)", i, gnt_who_q[i], i % 2); end
        end
        for (int i = 1; i < gnt_cyc_q.size(); i++) begin
            checks++; if (gnt_cyc_q[i] - gnt_cyc_q[i-1] != PERIOD) begin
                errors++; $display("FAIL cont_period%0d: got %0d want %0d", i, gnt_cyc_q[i] - gnt_cyc_q[i-1], PERIOD); end
        end
        checks++; if (both_cnt != 0) begin errors++; $display("FAIL cont_both_gnt: got %0d want 0", both_cnt); end
        checks++; if (done_cnt != 4) begin errors++; $display("FAIL cont_done: got %0d want 4", done_cnt); end
        if (wen_data_q.size() > NBYTES + 1) begin
            checks++; if (wen_data_q[NBYTES + 1] !== 8'h22) begin
                errors++; $display("FAIL cont_rpt_addr: got %h want 22", wen_data_q[NBYTES + 1]); end
        end
    endtask

    task automatic test_backpressure();
        bit granted, ok;
        int n, stall_cnt, rise_cyc;
        clear_mon();
        tx_rdy = 1'b1;
        request_ack(8'h5A, 32'hCAFE_F00D, 1'b0, granted);
        checks++; if (!granted) begin errors++; $display("FAIL bp_grant: got none want ack_gnt pulse"); end
        n = 0;
        while (wen_cyc_q.size() < 3 && n < 100) begin @(negedge clk); n++; end
        tx_rdy = 1'b0;
        repeat (100) @(negedge clk);
        stall_cnt = wen_cyc_q.size();
        rise_cyc = cyc;
        tx_rdy = 1'b1;
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_idle: busy_o still 1 want 0"); end
        checks++; if (stall_cnt != 3) begin errors++; $display("FAIL bp_stall_strobes: got %0d want 3", stall_cnt); end
        if (wen_cyc_q.size() > 3) begin
            checks++; if (wen_cyc_q[3] != rise_cyc + 1) begin
                errors++; $display("FAIL bp_resume: got cycle %0d want %0d", wen_cyc_q[3], rise_cyc + 1); end
        end
        make_exp(8'h5A, 32'hCAFE_F00D);
        checks++; if (wen_data_q.size() != NBYTES) begin
            errors++; $display("FAIL bp_strobes: got %0d want %0d", wen_data_q.size(), NBYTES); end
        for (int i = 0; i < wen_data_q.size() && i < NBYTES; i++) begin
            checks++; if (wen_data_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL bp_byte%0d: got %h want %h", i, wen_data_q[i], exp_q[i]); end
        end
        checks++; if (done_cnt != 1 || err_cnt != 0) begin
            errors++; $display("FAIL bp_pulses: got done=%0d err=%0d want 1 0", done_cnt, err_cnt); end
    endtask

    task automatic test_watchdog();
        int n, done_at_err;
        clear_mon();
        ack_addr = 8'h77; ack_data = 32'h0102_0304;
        wd_rdy = 1'b1;
        wd_ack_req = 1'b1;
        n = 0;
        while (wd_gnt_cyc_q.size() < 1 && n < 20) begin @(negedge clk); n++; end
        wd_ack_req = 1'b0;
        n = 0;
        while (wd_wen_cyc_q.size() < 2 && n < 40) begin @(negedge clk); n++; end
        wd_rdy = 1'b0;
        wd_ack_req = 1'b1;
        n = 0;
        while (wd_err_cnt == 0 && n < 120) begin @(negedge clk); n++; end
        done_at_err = wd_done_cnt;
        @(negedge clk);
        wd_ack_req = 1'b0;
        wd_rdy = 1'b1;
        n = 0;
        while (wd_busy !== 1'b0 && n < PERIOD + 20) begin @(negedge clk); n++; end
        @(negedge clk);
        checks++; if (wd_err_cnt != 1) begin errors++; $display("FAIL wd_err_count: got %0d want 1", wd_err_cnt); end
        if (wd_wen_cyc_q.size() >= 2) begin
            checks++; if (wd_err_cyc != wd_wen_cyc_q[1] + GUARD + 1 + 50) begin
                errors++; $display("FAIL wd_err_time: got %0d want %0d", wd_err_cyc, wd_wen_cyc_q[1] + GUARD + 51); end
        end
        checks++; if (wd_busy_at_err !== 1'b0) begin
            errors++; $display("FAIL wd_busy_at_err: got %b want 0", wd_busy_at_err); end
        checks++; if (done_at_err != 0) begin
            errors++; $display("FAIL wd_no_done: got %0d want 0", done_at_err); end
        checks++; if (wd_gnt_cyc_q.size() != 2) begin
            errors++; $display("FAIL wd_gnt_count: got %0d want 2", wd_gnt_cyc_q.size()); end
        if (wd_gnt_cyc_q.size() >= 2) begin
            checks++; if (wd_gnt_cyc_q[1] != wd_err_cyc + 1) begin
                errors++; $display("FAIL wd_regrant: got %0d want %0d", wd_gnt_cyc_q[1], wd_err_cyc + 1); end
        end
        checks++; if (wd_done_cnt != 1 || wd_busy !== 1'b0) begin
            errors++; $display("FAIL wd_second_frame: got done=%0d busy=%b want 1 0", wd_done_cnt, wd_busy); end
        checks++; if (wd_wen_cyc_q.size() != 2 + NBYTES) begin
            errors++; $display("FAIL wd_strobes: got %0d want %0d", wd_wen_cyc_q.size(), 2 + NBYTES); end
    endtask

    task automatic test_input_change();
        bit granted, ok;
        clear_mon();
        tx_rdy = 1'b1;
        request_ack(8'h03, 32'h1234_5678, 1'b1, granted);
        checks++; if (!granted) begin errors++; $display("FAIL chg_grant: got none want ack_gnt pulse"); end
        wait_idle(400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL chg_idle: busy_o still 1 want 0"); end
        make_exp(8'h03, 32'h1234_5678);
        checks++; if (wen_data_q.size() != NBYTES) begin
            errors++; $display("FAIL chg_strobes: got %0d want %0d", wen_data_q.size(), NBYTES); end
        for (int i = 0; i < wen_data_q.size() && i < NBYTES; i++) begin
            checks++; if (wen_data_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL chg_byte%0d: got %h want %h", i, wen_data_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit granted, ok;
        int n;
        clear_mon();
        tx_rdy = 1'b1;
        request_ack(8'h03, 32'h1234_5678, 1'b0, granted);
        n = 0;
        while (wen_cyc_q.size() < 3 && n < 100) begin @(negedge clk); n++; end
        reset_n = 1'b0;
        #1;
        checks++; if (wen !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid_async: got wen=%b busy=%b want 1 0", wen, busy); end
        checks++; if (tx_data !== 8'h00 || state_dbg !== 3'd0) begin
            errors++; $display("FAIL rst_mid_regs: got tx_data=%h state=%0d want 00 0", tx_data, state_dbg); end
        ack_req = 1'b1; rpt_req = 1'b1;
        @(negedge clk);
        clear_mon();
        reset_n = 1'b1;
        @(negedge clk);
        ack_req = 1'b0; rpt_req = 1'b0;
        checks++; if (gnt_who_q.size() != 1 || gnt_who_q[0] != 0) begin
            errors++; $display("FAIL rst_mid_first_gnt: got %0d grants (first=%0d) want 1 ack(0)",
                               gnt_who_q.size(), gnt_who_q.size() > 0 ? gnt_who_q[0] : -1); end
        wait_idle(400, ok);
        checks++; if (err_cnt != 0 || done_cnt != 1) begin
            errors++; $display("FAIL rst_mid_pulses: got err=%0d done=%0d want 0 1", err_cnt, done_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_ack();
        test_contention();
        test_backpressure();
        test_watchdog();
        test_input_change();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Transmit-side controller for the COREUART instance in the UART interface; the receive path already owns RXRDY/OEN.
- Arbitrates between two frame requesters: command-ack from the receive path and periodic status/readback.
- Serialises each granted 8-bit address + 32-bit data word into a fixed byte frame.
- Drives COREUART WEN/DATA_IN using its TXRDY handshake, with a TXRDY watchdog.

Parameters:
SYNC_BYTE, 8'hA5, first byte of every frame
GUARD_CYC, 4, cycles waited after a WEN strobe before TXRDY is trusted again (range 1..15)
TIMEOUT_CYC, 65535, max cycles in WAIT_RDY before the frame is aborted (16-bit counter)

Ports:
sys_clk_i  in  1  system clock
reset_i  in  1  asynchronous active-low reset
ack_req_i  in  1  ack requester wants a frame; level, held until grant
ack_addr_i  in  8  ack frame address, stable while ack_req_i=1
ack_data_i  in  32  ack frame data, stable while ack_req_i=1
ack_gnt_o  out  1  one-cycle grant; ack inputs captured this cycle
rpt_req_i  in  1  report requester wants a frame
rpt_addr_i  in  8  report frame address
rpt_data_i  in  32  report frame data
rpt_gnt_o  out  1  one-cycle grant for report requester
tx_rdy_i  in  1  COREUART TXRDY
wen_o  out  1  COREUART WEN, active-low strobe
tx_data_o  out  8  COREUART DATA_IN
busy_o  out  1  frame in progress (any state except IDLE)
frame_done_o  out  1  one-cycle pulse, last byte accepted
err_o  out  1  one-cycle pulse, frame aborted by watchdog

Behaviour:
- Reset (async, reset_i=0):
  - outputs: wen_o=1, tx_data_o=0, gnts=0, busy_o=0, frame_done_o=0, err_o=0
  - internal: state=IDLE, byte_idx=0, last_grant=RPT (ack wins first contention)
  - Reset mid-frame aborts the frame silently; no err_o.
- Frame order: SYNC_BYTE, addr, data[31:24], data[23:16], data[15:8], data[7:0]; 6 bytes, last byte_idx=5.
- States:
  - IDLE:
    - Only one request active: grant it.
    - Both active: grant the one not equal to last_grant (round-robin), then update last_grant.
    - Grant cycle: gnt_o=1, addr/data captured into a 40-bit shadow, byte_idx=0, next state WAIT_RDY.
    - No req: stay.
  - WAIT_RDY:
    - tx_rdy_i=1: go to WRITE.
    - Otherwise increment timeout counter; at TIMEOUT_CYC-1, err_o=1 for 1 cycle and go to IDLE. No gnt is issued in that cycle.
    - Counter clears on entry.
  - WRITE:
    - Exactly one cycle: wen_o=0, tx_data_o=byte[byte_idx].
    - tx_data_o is registered and held unchanged until the next WRITE.
  - GUARD:
    - Count GUARD_CYC cycles, wen_o=1.
    - Then, if byte_idx=last, go to DONE; else byte_idx+1 and go to WAIT_RDY.
  - DONE: frame_done_o=1 for one cycle, then IDLE.
- Timing:
  - Earliest next grant is the cycle after DONE.
  - Grant-to-first-WEN minimum is 2 cycles (grant, WAIT_RDY seeing tx_rdy_i=1, WRITE).
- Requester rule: a req held high after gnt is a new request, eligible in the next IDLE.
- Requests are ignored outside IDLE; input changes after the grant do not affect the frame in flight.
- Never more than one gnt per frame; ack_gnt_o and rpt_gnt_o are never high together.

Optional Feature:
- Macro: UART_TX_CHECKSUM_EN.
- Defined:
  - Appends a 7th byte = XOR of addr and the four data bytes (SYNC excluded); last byte_idx=6.
  - frame_done_o pulses after the checksum byte.
- Undefined: 6-byte frames only; no checksum logic present.

Test Plan:
- Single ack frame:
  - Stimulus: ack_req_i=1, addr=8'h03, data=32'h12345678; tx_rdy_i held 1.
  - Response: ack_gnt_o pulse; wen_o low 6 times with tx_data_o A5,03,12,34,56,78, each strobe GUARD_CYC+2 cycles apart; frame_done_o 1 pulse.
  - With UART_TX_CHECKSUM_EN: 7th byte 8'h0B.
- Contention:
  - Stimulus: ack_req_i and rpt_req_i high from reset, both held high.
  - Response: grants alternate ack, rpt, ack, rpt across four frames; never both in one cycle.
- TXRDY backpressure:
  - Stimulus: tx_rdy_i low for 100 cycles before byte 3.
  - Response: wen_o stays high during the stall; byte 3 sent 1 cycle after tx_rdy_i rises; frame completes normally.
- Watchdog:
  - Stimulus: TIMEOUT_CYC=50; tx_rdy_i stuck 0 after byte 1.
  - Response: err_o pulse exactly 50 cycles into WAIT_RDY; busy_o drops; no frame_done_o; the next request is granted.
- Input change after grant:
  - Stimulus: change ack_data_i to 32'hFFFFFFFF the cycle after grant.
  - Response: transmitted bytes still match the captured 32'h12345678.
- Reset mid-frame:
  - Stimulus: reset_i=0 during GUARD of byte 2.
  - Response: wen_o=1 and busy_o=0 immediately (async); after release, the first contended grant goes to ack.
